// File: rtl/riscv_instr_mem_pkg.sv
// Shared types for the instruction-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_instr_mem_pkg;

    // Deepest supported gnt-to-rvalid latency.
    localparam int RVALID_LAT_MAX = 4;

    // One response-pipe slot.
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rsp_t;

    // Grant FSM states.
    typedef enum logic {
        IDLE,
        WAIT
    } gnt_state_e;

endpackage

// File: rtl/riscv_instr_mem_rsp_pipe.sv
// Fixed-depth response shift register. Data is pushed on grant and delivered from the head.
// Latency: DEPTH cycles from push to head.
// Backpressure: none; the pipe advances every cycle.
// Ports: clk, rst (sync, active-high), push_i (slot entering stage 0), head_o (last stage).
module riscv_instr_mem_rsp_pipe
    import riscv_instr_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  rsp_t push_i,
    output rsp_t head_o
);

    rsp_t stage_q [DEPTH];

    // Valid bits always shift. Data only moves along with a valid bit, so the
    // head keeps the last delivered word while nothing is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0].valid <= push_i.valid;
            if (push_i.valid) begin
                stage_q[0].data <= push_i.data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i].valid <= stage_q[i-1].valid;
                if (stage_q[i-1].valid) begin
                    stage_q[i].data <= stage_q[i-1].data;
                end
            end
        end
    end

    assign head_o = stage_q[DEPTH-1];

endmodule

// File: rtl/riscv_instr_mem_responder.sv
// Memory-side responder for instruction fetch (req/gnt/rvalid) with PMP range check and backdoor write port.
// Latency: gnt after GNT_WAIT request cycles (0 = same cycle), rvalid RVALID_LAT cycles after gnt.
// Backpressure: stall_i suppresses gnt; responses are never back-pressured.
// Ports: clk/rst; instr_req_i, instr_addr_i -> instr_gnt_o, instr_rdata_o, instr_rvalid_o, instr_err_pmp_o;
//        pmp_en_i/pmp_base_i/pmp_limit_i define the allowed window; stall_i; we_i/waddr_i/wdata_i backdoor write.
module riscv_instr_mem_responder
    import riscv_instr_mem_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int GNT_WAIT   = 0,
    parameter int RVALID_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_pmp_o,
    input  logic        pmp_en_i,
    input  logic [31:0] pmp_base_i,
    input  logic [31:0] pmp_limit_i,
    input  logic        stall_i,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (GNT_WAIT < 2) ? 1 : $clog2(GNT_WAIT + 1);
    localparam logic [CW-1:0] GNT_WAIT_C = CW'(GNT_WAIT);
    // Out-of-range latencies are clamped into 1..RVALID_LAT_MAX.
    localparam int LAT = (RVALID_LAT < 1) ? 1 :
                         (RVALID_LAT > RVALID_LAT_MAX) ? RVALID_LAT_MAX : RVALID_LAT;

    logic [31:0]   mem_q [MEM_WORDS];
    gnt_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pmp_err;
    logic          gnt;
    logic [AW-1:0] ridx, widx;
    rsp_t          push, head;
    logic          unused_addr_bits;

    // Only the word-index bits select a RAM word; higher addresses alias.
    assign ridx = instr_addr_i[AW+1:2];
    assign widx = waddr_i[AW+1:2];
    assign unused_addr_bits = ^{instr_addr_i[31:AW+2], instr_addr_i[1:0],
                                waddr_i[31:AW+2], waddr_i[1:0]};

    assign pmp_err = instr_req_i & pmp_en_i &
                     ((instr_addr_i < pmp_base_i) | (instr_addr_i >= pmp_limit_i));

    // Grant FSM. gnt is combinational so a zero-wait grant lands in the request cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        if (!instr_req_i || pmp_err) begin
            // Dropped or faulting request abandons any wait in progress.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!stall_i) begin
                        if (GNT_WAIT == 0) begin
                            gnt = 1'b1;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == GNT_WAIT_C) begin
                        // Stall holds the count at its terminal value.
                        if (!stall_i) begin
                            gnt     = 1'b1;
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        if (rst) begin
            gnt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM is never reset; the backdoor write works even while rst is high.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx] <= wdata_i;
        end
    end

    // Asynchronous read captured into the pipe at the grant edge, so a
    // same-cycle backdoor write to that word is not yet visible.
    always_comb begin
        push.valid = gnt;
        push.data  = mem_q[ridx];
    end

    riscv_instr_mem_rsp_pipe #(
        .DEPTH (LAT)
    ) u_rsp_pipe (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .head_o (head)
    );

    assign instr_gnt_o     = gnt;
    assign instr_rvalid_o  = head.valid;
    assign instr_rdata_o   = head.data;
    assign instr_err_pmp_o = pmp_err;

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
module tb_riscv_instr_mem_responder;

    localparam int NI   = 3;     // u_a: GW0/L1, u_b: GW2/L1, u_c: GW0/L3
    localparam int SLOTS = 4096;

    logic        clk = 1'b0;
    logic        rst, req, pmp_en, stall, we;
    logic [31:0] addr, pmp_base, pmp_limit, waddr, wdata;
    logic [NI-1:0] gnt, rvalid, err;
    logic [31:0] rdata [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [1024];
    logic        sched_v [NI][SLOTS];
    logic [31:0] sched_d [NI][SLOTS];
    int          waited  [NI];
    logic [31:0] last_rd [NI];

    always #5 clk = ~clk;

    riscv_instr_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(0), .RVALID_LAT(1)) u_a (
        .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[0]),
        .instr_rdata_o(rdata[0]), .instr_rvalid_o(rvalid[0]), .instr_err_pmp_o(err[0]),
        .pmp_en_i(pmp_en), .pmp_base_i(pmp_base), .pmp_limit_i(pmp_limit), .stall_i(stall),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata));

    riscv_instr_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(2), .RVALID_LAT(1)) u_b (
        .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[1]),
        .instr_rdata_o(rdata[1]), .instr_rvalid_o(rvalid[1]), .instr_err_pmp_o(err[1]),
        .pmp_en_i(pmp_en), .pmp_base_i(pmp_base), .pmp_limit_i(pmp_limit), .stall_i(stall),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata));

    riscv_instr_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(0), .RVALID_LAT(3)) u_c (
        .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[2]),
        .instr_rdata_o(rdata[2]), .instr_rvalid_o(rvalid[2]), .instr_err_pmp_o(err[2]),
        .pmp_en_i(pmp_en), .pmp_base_i(pmp_base), .pmp_limit_i(pmp_limit), .stall_i(stall),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata));

    function automatic int gw_of(int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic int lat_of(int i);
        return (i == 2) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] old;
        logic        e_err, e_gnt, elig, e_v;
        int          slot;

        rst = 1'b1; req = 1'b0; addr = '0; pmp_en = 1'b0; pmp_base = '0; pmp_limit = '0;
        stall = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        @(negedge clk);

        // Preload words 0..127 under reset, odd words through an aliased address.
        for (int i = 0; i < 128; i++) begin
            we    = 1'b1;
            waddr = (32'(i) << 2) | (32'(i & 1) << 20);
            wdata = $urandom;
            mem_m[i] = wdata;
            @(negedge clk);
        end
        we = 1'b0;

        // Reset held with req high.
        for (int k = 0; k < 3; k++) begin
            req = 1'b1; addr = 32'h0;
            #1;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'd0);
                chk($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
                chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
            end
            @(negedge clk);
        end
        rst = 1'b0;

        // Streaming on u_a: 0x0,0x4,0x8,0xC back to back.
        for (int k = 0; k < 5; k++) begin
            req = (k < 4); addr = 32'(k * 4);
            #1;
            if (k < 4) chk($sformatf("stream_gnt%0d", k), 32'(gnt[0]), 32'd1);
            if (k >= 1) begin
                chk($sformatf("stream_rvalid%0d", k), 32'(rvalid[0]), 32'd1);
                chk($sformatf("stream_rdata%0d", k), rdata[0], mem_m[k-1]);
            end else begin
                chk("stream_rvalid0", 32'(rvalid[0]), 32'd0);
            end
            @(negedge clk);
        end
        req = 1'b0;
        repeat (6) @(negedge clk);

        // Wait states on u_b, address changes while waiting.
        for (int k = 0; k < 4; k++) begin
            req = (k < 3); addr = (k == 0) ? 32'h10 : 32'h40;
            #1;
            if (k < 3) chk($sformatf("wait_gnt%0d", k), 32'(gnt[1]), 32'(k == 2));
            if (k == 3) begin
                chk("wait_rvalid", 32'(rvalid[1]), 32'd1);
                chk("wait_rdata", rdata[1], mem_m[16]);
            end
            @(negedge clk);
        end
        req = 1'b0;
        repeat (3) @(negedge clk);

        // Stall on the would-be grant cycle delays gnt by one.
        for (int k = 0; k < 5; k++) begin
            req = (k < 4); addr = 32'h20; stall = (k == 2);
            #1;
            if (k < 4) chk($sformatf("stall_gnt%0d", k), 32'(gnt[1]), 32'(k == 3));
            if (k == 3) chk("stall_rvalid_early", 32'(rvalid[1]), 32'd0);
            if (k == 4) begin
                chk("stall_rvalid", 32'(rvalid[1]), 32'd1);
                chk("stall_rdata", rdata[1], mem_m[8]);
            end
            @(negedge clk);
        end
        req = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);

        // PMP window [0x100, 0x200).
        pmp_en = 1'b1; pmp_base = 32'h100; pmp_limit = 32'h200;
        req = 1'b1; addr = 32'h200;
        #1;
        chk("pmp_err_limit", 32'(err[0]), 32'd1);
        chk("pmp_gnt_a", 32'(gnt[0]), 32'd0);
        chk("pmp_gnt_b", 32'(gnt[1]), 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("pmp_no_rvalid", 32'(rvalid[0]), 32'd0);
        chk("pmp_err_noreq", 32'(err[0]), 32'd0);
        @(negedge clk);
        req = 1'b1; addr = 32'h1FC;
        #1;
        chk("pmp_err_in", 32'(err[0]), 32'd0);
        chk("pmp_gnt_in", 32'(gnt[0]), 32'd1);
        @(negedge clk);
        req = 1'b1; addr = 32'hFC;
        #1;
        chk("pmp_rvalid_in", 32'(rvalid[0]), 32'd1);
        chk("pmp_rdata_in", rdata[0], mem_m[127]);
        chk("pmp_err_below", 32'(err[0]), 32'd1);
        @(negedge clk);
        addr = 32'h100;
        #1;
        chk("pmp_err_base", 32'(err[0]), 32'd0);
        @(negedge clk);
        req = 1'b0; pmp_en = 1'b0;
        repeat (5) @(negedge clk);

        // Latency 3 on u_c: three back-to-back grants, then in-order responses.
        for (int k = 0; k < 7; k++) begin
            req = (k < 3); addr = 32'(k * 4);
            #1;
            if (k < 3) chk($sformatf("lat_gnt%0d", k), 32'(gnt[2]), 32'd1);
            if (k < 3 || k == 6) begin
                chk($sformatf("lat_norv%0d", k), 32'(rvalid[2]), 32'd0);
            end else begin
                chk($sformatf("lat_rvalid%0d", k), 32'(rvalid[2]), 32'd1);
                chk($sformatf("lat_rdata%0d", k), rdata[2], mem_m[k-3]);
            end
            @(negedge clk);
        end

        // Reset one cycle after the last grant discards the in-flight responses.
        for (int k = 0; k < 3; k++) begin
            req = 1'b1; addr = 32'h10 + 32'(k * 4);
            #1;
            chk($sformatf("abort_gnt%0d", k), 32'(gnt[2]), 32'd1);
            @(negedge clk);
        end
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("abort_norv%0d", k), 32'(rvalid[2]), 32'd0);
            chk($sformatf("abort_rdata%0d", k), rdata[2], 32'd0);
            @(negedge clk);
        end

        // Aliased read of 0x1000 while writing 0x0 returns the old word.
        we = 1'b1; waddr = 32'h0; wdata = 32'hDEAD_BEEF; req = 1'b1; addr = 32'h1000;
        #1;
        chk("alias_gnt0", 32'(gnt[0]), 32'd1);
        @(negedge clk);
        old = mem_m[0];
        mem_m[0] = 32'hDEAD_BEEF;
        we = 1'b0;
        #1;
        chk("alias_rvalid_old", 32'(rvalid[0]), 32'd1);
        chk("alias_rdata_old", rdata[0], old);
        chk("alias_gnt1", 32'(gnt[0]), 32'd1);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("alias_rvalid_new", 32'(rvalid[0]), 32'd1);
        chk("alias_rdata_new", rdata[0], 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        chk("hold_rvalid", 32'(rvalid[0]), 32'd0);
        chk("hold_rdata", rdata[0], 32'hDEAD_BEEF);
        @(negedge clk);

        // Randomized phase against the reference model, from a clean reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            waited[i]  = 0;
            last_rd[i] = '0;
            for (int s = 0; s < SLOTS; s++) sched_v[i][s] = 1'b0;
        end

        for (int n = 0; n < 2000; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            req   = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) addr = $urandom & 32'hFFFF_F1FF;
            else                           addr = 32'($urandom_range(0, 127)) << 2;
            if (n % 16 == 0) begin
                pmp_en    = ($urandom_range(0, 1) == 1);
                pmp_base  = 32'($urandom_range(0, 64)) << 2;
                pmp_limit = 32'($urandom_range(48, 160)) << 2;
            end
            we    = ($urandom_range(0, 4) == 0);
            waddr = (32'($urandom_range(0, 127)) << 2) | ($urandom & 32'hFFFF_F000);
            wdata = $urandom;
            #1;
            slot = n % SLOTS;
            for (int i = 0; i < NI; i++) begin
                e_err = req & pmp_en & ((addr < pmp_base) | (addr >= pmp_limit));
                elig  = req & ~e_err;
                e_gnt = 1'b0;
                if (!rst && elig && waited[i] >= gw_of(i) && !stall) e_gnt = 1'b1;
                e_v = sched_v[i][slot];
                if (e_v) last_rd[i] = sched_d[i][slot];
                chk($sformatf("rnd%0d_err%0d", n, i), 32'(err[i]), 32'(e_err));
                chk($sformatf("rnd%0d_gnt%0d", n, i), 32'(gnt[i]), 32'(e_gnt));
                chk($sformatf("rnd%0d_rvalid%0d", n, i), 32'(rvalid[i]), 32'(e_v));
                chk($sformatf("rnd%0d_rdata%0d", n, i), rdata[i], last_rd[i]);
                sched_v[i][slot] = 1'b0;
                if (rst) begin
                    waited[i]  = 0;
                    last_rd[i] = '0;
                    for (int s = 0; s < SLOTS; s++) sched_v[i][s] = 1'b0;
                end else begin
                    if (!elig)                           waited[i] = 0;
                    else if (waited[i] >= gw_of(i))      waited[i] = stall ? waited[i] : 0;
                    else if (!(waited[i] == 0 && stall)) waited[i] = waited[i] + 1;
                    if (e_gnt) begin
                        sched_v[i][(n + lat_of(i)) % SLOTS] = 1'b1;
                        sched_d[i][(n + lat_of(i)) % SLOTS] = mem_m[addr[11:2]];
                    end
                end
            end
            if (we) mem_m[waddr[11:2]] = wdata;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
